// File: rtl/mem_pkg.sv
// Shared constants and types for the matrix-memory bus arbiter.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (round-robin tie break).
package mem_pkg;

   localparam int ADDR_W    = 3;
   localparam int DATA_W    = 256;
   localparam int NUM_PORTS = 2;

   // Read/write select encoding as seen by the memory's ReadWrite pin
   localparam logic MEM_READ  = 1'b1;
   localparam logic MEM_WRITE = 1'b0;

   // Sequencer states: idle, address setup, enabled access, read capture
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETUP   = 2'd1,
      ACCESS  = 2'd2,
      CAPTURE = 2'd3
   } state_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester handshakes plus memory control/data bus for the arbiter.
// The master view is the requesters and memory side; the slave view is the arbiter.
interface mem_bus_arbiter_if;
   import mem_pkg::*;

   logic              req0;
   logic              req1;
   logic              rw0;
   logic              rw1;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic              ack0;
   logic              ack1;
   logic [DATA_W-1:0] rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_nEnable;
   logic              mem_ReadWrite;
   logic [DATA_W-1:0] bus_out;
   logic              bus_oe;
   logic [DATA_W-1:0] bus_in;

   modport master (
      output req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, bus_in,
      input  ack0, ack1, rdata, mem_addr, mem_nEnable, mem_ReadWrite, bus_out, bus_oe
   );

   modport slave (
      input  req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, bus_in,
      output ack0, ack1, rdata, mem_addr, mem_nEnable, mem_ReadWrite, bus_out, bus_oe
   );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the two requesters.
// With MEM_ARB_ROUND_ROBIN_EN a tie goes to the port not granted last;
// otherwise port 0 always wins a tie and there is no pointer input.
module mem_arb_pick
   import mem_pkg::*;
(
   input  logic [NUM_PORTS-1:0] elig,
`ifdef MEM_ARB_ROUND_ROBIN_EN
   input  logic                 last,
`endif
   output logic                 grant_valid,
   output logic                 grant_id
);

   // Pick a single winner; a lone requester always wins
   always_comb begin
      grant_valid = |elig;
      grant_id    = 1'b0;
      case (elig)
         2'b10:   grant_id = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         2'b11:   grant_id = ~last;
`else
         2'b11:   grant_id = 1'b0;
`endif
         default: grant_id = 1'b0;
      endcase
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter and access sequencer for the 8 x 256-bit matrix memory.
// Optional macro MEM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking;
// without it port 0 has fixed priority.
module mem_bus_arbiter
   import mem_pkg::*;
(
   input logic              clk,
   input logic              Reset,
   mem_bus_arbiter_if.slave bus
);

   state_t                state_reg;
   state_t                state_next;

   // Transaction latched at grant time; requesters may change inputs afterwards
   logic                  grant_id_reg;
   logic                  rw_reg;
   logic [ADDR_W-1:0]     addr_reg;
   logic [DATA_W-1:0]     wdata_reg;
   logic [DATA_W-1:0]     rdata_reg;
   logic [NUM_PORTS-1:0]  ack_reg;

   logic [NUM_PORTS-1:0]  req_vec;
   logic [NUM_PORTS-1:0]  elig;
   logic                  grant_valid;
   logic                  grant_id;
   logic                  grant_take;
   logic                  ack_set;
   logic                  nenable;
   logic                  oe;

   assign req_vec = {bus.req1, bus.req0};

   // A port whose ack is showing this cycle is still holding req from the
   // finished transaction, so it must not be granted again yet.
   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_elig
      assign elig[gi] = req_vec[gi] & ~ack_reg[gi];
   end

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic last_reg;

   // Remember the most recent winner; reset to port 1 so port 0 wins the first tie
   always_ff @(posedge clk) begin
      if (Reset) begin
         last_reg <= 1'b1;
      end else if (grant_take) begin
         last_reg <= grant_id;
      end
   end

   mem_arb_pick u_pick (
      .elig        (elig),
      .last        (last_reg),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );
`else
   mem_arb_pick u_pick (
      .elig        (elig),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );
`endif

   assign grant_take = (state_reg == IDLE) && grant_valid;

   // Writes finish at the end of ACCESS, reads one cycle later after capture
   assign ack_set = ((state_reg == ACCESS) && (rw_reg == MEM_WRITE)) ||
                    (state_reg == CAPTURE);

   // FSM state register
   always_ff @(posedge clk) begin
      if (Reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // FSM next-state: fixed setup/access sequence, extra capture cycle for reads
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (grant_valid) state_next = SETUP;
         SETUP:   state_next = ACCESS;
         ACCESS:  state_next = (rw_reg == MEM_READ) ? CAPTURE : IDLE;
         CAPTURE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs: enable only in ACCESS/CAPTURE, bus driven only for writes
   always_comb begin
      nenable = 1'b1;
      oe      = 1'b0;
      case (state_reg)
         SETUP: begin
            oe = (rw_reg == MEM_WRITE);
         end
         ACCESS: begin
            nenable = 1'b0;
            oe      = (rw_reg == MEM_WRITE);
         end
         CAPTURE: begin
            nenable = 1'b0;
         end
         default: begin
            nenable = 1'b1;
            oe      = 1'b0;
         end
      endcase
   end

   // Datapath: latch winner request at grant, pulse ack, capture read word
   always_ff @(posedge clk) begin
      if (Reset) begin
         grant_id_reg <= 1'b0;
         rw_reg       <= MEM_WRITE;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         rdata_reg    <= '0;
         ack_reg      <= '0;
      end else begin
         ack_reg <= '0;
         if (grant_take) begin
            grant_id_reg <= grant_id;
            if (grant_id) begin
               rw_reg    <= bus.rw1;
               addr_reg  <= bus.addr1;
               wdata_reg <= bus.wdata1;
            end else begin
               rw_reg    <= bus.rw0;
               addr_reg  <= bus.addr0;
               wdata_reg <= bus.wdata0;
            end
         end
         if (ack_set) begin
            ack_reg[grant_id_reg] <= 1'b1;
         end
         if (state_reg == CAPTURE) begin
            rdata_reg <= bus.bus_in;
         end
      end
   end

   // Address and direction are register-held, so they keep their last value in IDLE;
   // direction never reads while oe is high because both come from rw_reg.
   assign bus.mem_addr      = addr_reg;
   assign bus.mem_ReadWrite = rw_reg;
   assign bus.mem_nEnable   = nenable;
   assign bus.bus_oe        = oe;
   assign bus.bus_out       = wdata_reg;
   assign bus.rdata         = rdata_reg;
   assign bus.ack0          = ack_reg[0];
   assign bus.ack1          = ack_reg[1];

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed requests push expected acks,
// a negedge monitor pops and checks them. Expectations for ties follow
// MEM_ARB_ROUND_ROBIN_EN when it is defined.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
   import mem_pkg::*;

   logic clk = 1'b0;
   logic Reset;

   always #5 clk = ~clk;

   mem_bus_arbiter_if bus ();

   mem_bus_arbiter dut (
      .clk   (clk),
      .Reset (Reset),
      .bus   (bus)
   );

   typedef struct {
      int                port;
      bit                is_read;
      logic [DATA_W-1:0] data;
      int                cyc;
   } exp_t;

   exp_t exp_q[$];
   int   total   = 0;
   int   bad     = 0;
   int   cyc     = 0;
   int   oe_cnt  = 0;
   int   nen_cnt = 0;
   bit   hold0   = 1'b0;

   // Memory model: written on enabled write cycles, drives bus_in on enabled reads
   logic [DATA_W-1:0] mem [8];
   bit                mem_init = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 8; i++) mem[i] <= '0;
         mem[7]   <= 256'd77;
         mem_init <= 1'b1;
      end else if (!bus.mem_nEnable && bus.mem_ReadWrite == MEM_WRITE && bus.bus_oe) begin
         mem[bus.mem_addr] <= bus.bus_out;
      end
   end

   assign bus.bus_in = (!bus.mem_nEnable && bus.mem_ReadWrite == MEM_READ) ?
                       mem[bus.mem_addr] : '0;

   task automatic chk(input string name, input logic [DATA_W-1:0] act,
                      input logic [DATA_W-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Monitor: check bus safety every cycle and pop the scoreboard on each ack
   always @(negedge clk) begin
      exp_t e;
      if (Reset) begin
         oe_cnt  <= 0;
         nen_cnt <= 0;
      end else begin
         if (bus.bus_oe)
            chk("oe_while_read", DATA_W'(bus.mem_ReadWrite), DATA_W'(MEM_WRITE));
         if (bus.ack0 || bus.ack1) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_ack", DATA_W'({bus.ack1, bus.ack0}), '0);
            end else begin
               e = exp_q.pop_front();
               chk("ack_port", DATA_W'(bus.ack1), DATA_W'(e.port));
               chk("ack_cycle", DATA_W'(cyc), DATA_W'(e.cyc));
               if (e.is_read) begin
                  chk("rdata", bus.rdata, e.data);
                  chk("read_oe_cycles", DATA_W'(oe_cnt), DATA_W'(0));
                  chk("read_en_cycles", DATA_W'(nen_cnt), DATA_W'(2));
               end else begin
                  chk("write_oe_cycles", DATA_W'(oe_cnt), DATA_W'(2));
                  chk("write_en_cycles", DATA_W'(nen_cnt), DATA_W'(1));
               end
               $display("ack port=%0d cyc=%0d read=%0d rdata=%0h",
                        e.port, cyc, e.is_read, bus.rdata);
            end
            oe_cnt  <= 0;
            nen_cnt <= 0;
         end else begin
            if (bus.bus_oe)       oe_cnt  <= oe_cnt + 1;
            if (!bus.mem_nEnable) nen_cnt <= nen_cnt + 1;
         end
      end
   end

   // Advance one cycle; requesters drop req once they see their ack
   task automatic step();
      @(posedge clk);
      #1;
      if (bus.ack0 && !hold0) bus.req0 = 1'b0;
      if (bus.ack1)           bus.req1 = 1'b0;
   endtask

   task automatic start_req(input int port, input logic rw,
                            input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      if (port == 0) begin
         bus.req0 = 1'b1; bus.rw0 = rw; bus.addr0 = a; bus.wdata0 = d;
      end else begin
         bus.req1 = 1'b1; bus.rw1 = rw; bus.addr1 = a; bus.wdata1 = d;
      end
   endtask

   task automatic expect_ack(input int port, input bit is_read,
                             input logic [DATA_W-1:0] d, input int c);
      exp_t e;
      e.port = port; e.is_read = is_read; e.data = d; e.cyc = c;
      exp_q.push_back(e);
   endtask

   task automatic run_until_idle(input int max);
      int n = 0;
      while ((bus.req0 || bus.req1 || exp_q.size() != 0) && n < max) begin
         step();
         n++;
      end
      if (bus.req0 || bus.req1 || exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL timeout: pending=%0d after %0d cycles, required 0", exp_q.size(), n);
         exp_q.delete();
         bus.req0 = 1'b0;
         bus.req1 = 1'b0;
      end
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: sim time exceeded");
      $fatal(1, "global timeout");
   end

   initial begin
      int k;
      Reset      = 1'b1;
      bus.req0   = 1'b0; bus.req1   = 1'b0;
      bus.rw0    = 1'b0; bus.rw1    = 1'b0;
      bus.addr0  = '0;   bus.addr1  = '0;
      bus.wdata0 = '0;   bus.wdata1 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_nEnable",   DATA_W'(bus.mem_nEnable),   DATA_W'(1));
      chk("rst_bus_oe",    DATA_W'(bus.bus_oe),        DATA_W'(0));
      chk("rst_ack",       DATA_W'({bus.ack1, bus.ack0}), DATA_W'(0));
      chk("rst_rdata",     bus.rdata,                  '0);
      chk("rst_mem_addr",  DATA_W'(bus.mem_addr),      DATA_W'(0));
      chk("rst_ReadWrite", DATA_W'(bus.mem_ReadWrite), DATA_W'(0));
      chk("rst_bus_out",   bus.bus_out,                '0);
      Reset = 1'b0;
      step();
      step();

      // Port 0 writes 42 to addr 0
      start_req(0, MEM_WRITE, 3'd0, 256'd42);
      expect_ack(0, 1'b0, '0, cyc + 3);
      run_until_idle(20);

      // Port 1 reads it back
      start_req(1, MEM_READ, 3'd0, '0);
      expect_ack(1, 1'b1, 256'd42, cyc + 4);
      run_until_idle(20);

      // Tie: port 0 wins in both builds here (port 1 was granted last)
      k = cyc;
      start_req(0, MEM_WRITE, 3'd1, 256'd56);
      start_req(1, MEM_READ, 3'd7, '0);
      expect_ack(0, 1'b0, '0, k + 3);
      expect_ack(1, 1'b1, 256'd77, k + 7);
      run_until_idle(30);

      // Port 0 holds req across its ack with a new write; re-grant waits one edge
      k = cyc;
      start_req(0, MEM_WRITE, 3'd2, 256'd22);
      expect_ack(0, 1'b0, '0, k + 3);
      hold0 = 1'b1;
      for (int n = 0; n < 10 && !bus.ack0; n++) step();
      chk("hold_first_ack_seen", DATA_W'(bus.ack0), DATA_W'(1));
      bus.addr0  = 3'd5;
      bus.wdata0 = 256'd5;
      expect_ack(0, 1'b0, '0, cyc + 4);
      hold0 = 1'b0;
      run_until_idle(20);

      // Tie after a port 0 grant: round robin favours port 1, fixed favours port 0
      k = cyc;
      start_req(0, MEM_WRITE, 3'd3, 256'd33);
      start_req(1, MEM_READ, 3'd5, '0);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      expect_ack(1, 1'b1, 256'd5, k + 4);
      expect_ack(0, 1'b0, '0, k + 7);
`else
      expect_ack(0, 1'b0, '0, k + 3);
      expect_ack(1, 1'b1, 256'd5, k + 7);
`endif
      run_until_idle(30);

      // Reset during ACCESS of a write: no ack, bus released, registers cleared
      start_req(0, MEM_WRITE, 3'd6, 256'd66);
      step();
      step();
      chk("abort_in_access", DATA_W'(bus.mem_nEnable), DATA_W'(0));
      Reset    = 1'b1;
      bus.req0 = 1'b0;
      step();
      chk("abort_nEnable", DATA_W'(bus.mem_nEnable), DATA_W'(1));
      chk("abort_bus_oe",  DATA_W'(bus.bus_oe),      DATA_W'(0));
      chk("abort_ack",     DATA_W'(bus.ack0),        DATA_W'(0));
      Reset = 1'b0;
      step();
      chk("abort_rdata",     bus.rdata,                  '0);
      chk("abort_mem_addr",  DATA_W'(bus.mem_addr),      DATA_W'(0));
      chk("abort_ReadWrite", DATA_W'(bus.mem_ReadWrite), DATA_W'(0));
      chk("abort_bus_out",   bus.bus_out,                '0);
      chk("abort_no_ack",    DATA_W'({bus.ack1, bus.ack0}), DATA_W'(0));
      step();

      // Port 1 drops req during SETUP of a read of addr 2: still completes
      k = cyc;
      start_req(1, MEM_READ, 3'd2, '0);
      expect_ack(1, 1'b1, 256'd22, k + 4);
      step();
      bus.req1 = 1'b0;
      run_until_idle(20);

      // Read back the tie write, then a write must leave rdata untouched
      start_req(0, MEM_READ, 3'd3, '0);
      expect_ack(0, 1'b1, 256'd33, cyc + 4);
      run_until_idle(20);
      start_req(1, MEM_WRITE, 3'd4, 256'd9);
      expect_ack(1, 1'b0, '0, cyc + 3);
      run_until_idle(20);
      chk("rdata_held_after_write", bus.rdata, 256'd33);
      start_req(0, MEM_READ, 3'd4, '0);
      expect_ack(0, 1'b1, 256'd9, cyc + 4);
      run_until_idle(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
